register_file_param: RTL and testbench
======================================

# register_file_param

Parametrised multi-port register file, successor to the fixed 32×32, two-read, one-write CPU register file. It is generic in data width, depth, and read-port count. It adds a second write port with defined collision priority, optional write-to-read bypass, and a synchronous clear of all registers on reset. It sits in the datapath between instruction decode (addresses) and ALU/writeback (data), and is checked by the same self-checking bench style used for the current register file.

## Interface
Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers; power of two, ≥2
- AW, $clog2(DEPTH), address width (derived, not overridden)
- NREAD, 2, number of read ports, 1..8
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a read of an address being written this cycle returns the write data

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- WrEnA  in  1  write enable, port A
- Aw_a  in  AW  write address, port A
- Dw_a  in  WIDTH  write data, port A
- WrEnB  in  1  write enable, port B
- Aw_b  in  AW  write address, port B
- Dw_b  in  WIDTH  write data, port B
- Ar  in  NREAD*AW  packed read addresses; port i at [i*AW +: AW]
- Dr  out  NREAD*WIDTH  packed read data; port i at [i*WIDTH +: WIDTH]

## Operation
- Storage: DEPTH × WIDTH flops.
- Reads are combinational. Dr[i] follows Ar[i] and the current register contents with no clock.
- Writes: at the rising clk edge, if WrEnA, then reg[Aw_a] <= Dw_a. If WrEnB, then reg[Aw_b] <= Dw_b.
- Collision (WrEnA & WrEnB & Aw_a == Aw_b): port B wins. The register takes Dw_b.
- ZERO_REG=1:
  - A write to address 0 from either port is discarded.
  - Any read of address 0 returns 0, including under bypass.
  - Register 0 need not be implemented as flops.
- BYPASS=1:
  - If a write enable is high and Ar[i] equals that write address, Dr[i] returns the write data in the same cycle.
  - When both ports match, B has priority.
  - Address 0 is excluded when ZERO_REG=1.
- BYPASS=0: Dr[i] returns the pre-edge contents until the edge, then the new value.
- Reset: when rst_n=0 at a rising edge, all registers are cleared to 0. Writes in that cycle are ignored.
- Bypass is suppressed while rst_n=0. During reset Dr shows register contents, which read 0 after the first reset edge.
- Out-of-range addresses cannot occur, because DEPTH is a power of two.

## Timing
- Write latency: 1 edge. Data presented with WrEn before edge N is readable (non-bypass) immediately after edge N.
- Read latency: 0 cycles (combinational). With BYPASS=1, read-during-write latency is also 0.
- Reset value: every register is 0, so every Dr lane is 0 after the first clk edge with rst_n=0.
- Before the first reset, contents are X. Benches must reset first.
- Reset mid-sequence: a pending write in the reset cycle is lost. Writes resume on the first edge with rst_n=1.
- No handshake; there are no stall or back-pressure outputs.

## Structure
- Shared package regfile_pkg:
  - default WIDTH/DEPTH/NREAD constants
  - localparam ZERO_ADDR = 0
  - a function for packed-lane slicing (lane index → bit offset)
- Sub-module regfile_read_port: one combinational read lane containing the address mux, bypass compare (A then B priority), and zero-register force. It is instantiated NREAD times in a generate loop.
- The top module holds the storage array and the write-port logic with collision priority and reset clear.

## Test plan
- Reset clear: write 0xDEADBEEF to reg 7, assert rst_n=0 for one edge. Then read Ar[0]=7 → Dr[0]=0, and all lanes read 0.
- Basic write/read: WrEnA, Aw_a=4, Dw_a=69, clock one edge. Then Ar[0]=4, Ar[1]=4 → both lanes 69. Next, WrEnA=0 with Aw_a=4, Dw_a=42, clock → still 69.
- Zero register (ZERO_REG=1):
  - Write 69 to address 0 via A, and 55 via B on the next edge → Ar=0 reads 0 on every lane.
  - With BYPASS=1, a same-cycle read of 0 also reads 0.
- Collision: WrEnA=WrEnB=1, Aw_a=Aw_b=15, Dw_a=420, Dw_b=99, clock → reg 15 reads 99. Concurrent distinct writes (A: 3←11, B: 5←22) → reg 3=11, reg 5=22.
- Bypass (BYPASS=1): reg 9 holds 1. Drive WrEnB, Aw_b=9, Dw_b=77 with Ar[1]=9 before the edge → Dr[1]=77 combinationally. With BYPASS=0 the same stimulus → Dr[1]=1 before the edge and 77 after.
- Parametric sweep: run the above with WIDTH=16, DEPTH=8, NREAD=4. Write 0xFFFF to reg 7 → all four lanes addressed to 7 read 0xFFFF. Address wrap is checked by writing reg 0..7 with distinct values and reading back each.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file.
// Defaults match the classic 32x32, two-read CPU register file.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NREAD = 2;
  localparam int ZERO_ADDR = 0;

  // Bit offset of a lane inside a packed multi-lane bus.
  function automatic int lane_offset(input int lane, input int lane_width);
    return lane * lane_width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read lane: storage mux, same-cycle write bypass
// (port B over port A) and the hard-wired zero register.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] regs [DEPTH],
  input  logic             byp_en,
  input  logic             we_a,
  input  logic [AW-1:0]    wa_a,
  input  logic [WIDTH-1:0] wd_a,
  input  logic             we_b,
  input  logic [AW-1:0]    wa_b,
  input  logic [WIDTH-1:0] wd_b,
  output logic [WIDTH-1:0] rd_data
);

  always_comb begin
    // NOTE: rd_data gets a value before any condition so no path leaves it unassigned (no latch).
    rd_data = regs[rd_addr];
    if (BYPASS && byp_en) begin
      if (we_a && (wa_a == rd_addr)) rd_data = wd_a;
      if (we_b && (wa_b == rd_addr)) rd_data = wd_b;
    end
    // Zero register wins over everything, bypass included.
    if (ZERO_REG && (rd_addr == AW'(ZERO_ADDR))) rd_data = '0;
  end

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: DEPTH x WIDTH flops, two write ports
// (B wins collisions), NREAD combinational read lanes, synchronous clear.
module register_file_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NREAD    = DEF_NREAD,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   WrEnA,
  input  logic [AW-1:0]          Aw_a,
  input  logic [WIDTH-1:0]       Dw_a,
  input  logic                   WrEnB,
  input  logic [AW-1:0]          Aw_b,
  input  logic [WIDTH-1:0]       Dw_b,
  input  logic [NREAD*AW-1:0]    Ar,
  output logic [NREAD*WIDTH-1:0] Dr
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             wr_a_ok;
  logic             wr_b_ok;

  always_comb begin
    wr_a_ok = WrEnA && !(ZERO_REG && (Aw_a == AW'(ZERO_ADDR)));
    wr_b_ok = WrEnB && !(ZERO_REG && (Aw_b == AW'(ZERO_ADDR)));
    regs_d  = regs_q;
    // NOTE: blocking assignments apply in order, so port B's write lands last and wins a collision.
    if (wr_a_ok) regs_d[Aw_a] = Dw_a;
    if (wr_b_ok) regs_d[Aw_b] = Dw_b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: this array is plain flops, not an SRAM macro, so clearing every entry on reset is intended.
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .rd_addr (Ar[lane_offset(i, AW) +: AW]),
      .regs    (regs_q),
      .byp_en  (rst_n),
      .we_a    (WrEnA),
      .wa_a    (Aw_a),
      .wd_a    (Dw_a),
      .we_b    (WrEnB),
      .wa_b    (Aw_b),
      .wd_b    (Dw_b),
      .rd_data (Dr[lane_offset(i, WIDTH) +: WIDTH])
    );
  end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: a default instance (32x32, 2 reads, zero reg,
// bypass) and a small instance (16x8, 4 reads, no zero reg, no bypass).
module tb_register_file_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        we_a0, we_b0;
  logic [4:0]  aw_a0, aw_b0;
  logic [31:0] dw_a0, dw_b0;
  logic [9:0]  ar0;
  logic [63:0] dr0;

  logic        we_a1, we_b1;
  logic [2:0]  aw_a1, aw_b1;
  logic [15:0] dw_a1, dw_b1;
  logic [11:0] ar1;
  logic [63:0] dr1;

  int checks = 0;
  int errors = 0;

  register_file_param dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .WrEnA (we_a0),
    .Aw_a  (aw_a0),
    .Dw_a  (dw_a0),
    .WrEnB (we_b0),
    .Aw_b  (aw_b0),
    .Dw_b  (dw_b0),
    .Ar    (ar0),
    .Dr    (dr0)
  );

  register_file_param #(
    .WIDTH    (16),
    .DEPTH    (8),
    .NREAD    (4),
    .ZERO_REG (1'b0),
    .BYPASS   (1'b0)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .WrEnA (we_a1),
    .Aw_a  (aw_a1),
    .Dw_a  (dw_a1),
    .WrEnB (we_b1),
    .Aw_b  (aw_b1),
    .Dw_b  (dw_b1),
    .Ar    (ar1),
    .Dr    (dr1)
  );

  // Reference contents of each instance, updated from the write rules.
  logic [31:0] m0 [32];
  logic [15:0] m1 [8];

  function automatic logic [31:0] exp0(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (rst_n) begin
      if (we_b0 && aw_b0 == a) return dw_b0;
      if (we_a0 && aw_a0 == a) return dw_a0;
    end
    return m0[a];
  endfunction

  function automatic logic [15:0] exp1(input logic [2:0] a);
    return m1[a];
  endfunction

  task automatic idle();
    we_a0 = 1'b0; we_b0 = 1'b0; aw_a0 = '0; aw_b0 = '0; dw_a0 = '0; dw_b0 = '0;
    we_a1 = 1'b0; we_b1 = 1'b0; aw_a1 = '0; aw_b1 = '0; dw_a1 = '0; dw_b1 = '0;
  endtask

  // Apply the pending edge to the model, then clock the DUTs.
  task automatic tick();
    if (!rst_n) begin
      foreach (m0[i]) m0[i] = '0;
      foreach (m1[i]) m1[i] = '0;
    end else begin
      if (we_a0 && aw_a0 != 5'd0) m0[aw_a0] = dw_a0;
      if (we_b0 && aw_b0 != 5'd0) m0[aw_b0] = dw_b0;
      if (we_a1) m1[aw_a1] = dw_a1;
      if (we_b1) m1[aw_b1] = dw_b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    we_a0 = 1'b1; aw_a0 = 5'd7; dw_a0 = 32'hDEADBEEF;
    we_a1 = 1'b1; aw_a1 = 3'd7; dw_a1 = 16'hBEEF;
    tick();
    idle();
    rst_n = 1'b0;
    we_a0 = 1'b1; aw_a0 = 5'd7; dw_a0 = 32'h12345678;
    ar0 = {5'd7, 5'd7};
    #1;
    checks++;
    if (dr0[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_bypass_suppressed got %h exp %h", dr0[63:32], 32'hDEADBEEF);
    end
    tick();
    idle();
    for (int a = 0; a < 32; a++) begin
      ar0 = {a[4:0], a[4:0]};
      #1;
      for (int l = 0; l < 2; l++) begin
        checks++;
        if (dr0[l*32 +: 32] !== 32'd0) begin
          errors++;
          $display("FAIL reset_clear0 addr%0d lane%0d got %h exp 0", a, l, dr0[l*32 +: 32]);
        end
      end
    end
    for (int a = 0; a < 8; a++) begin
      ar1 = {4{a[2:0]}};
      #1;
      for (int l = 0; l < 4; l++) begin
        checks++;
        if (dr1[l*16 +: 16] !== 16'd0) begin
          errors++;
          $display("FAIL reset_clear1 addr%0d lane%0d got %h exp 0", a, l, dr1[l*16 +: 16]);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    idle();
    we_a0 = 1'b1; aw_a0 = 5'd4; dw_a0 = 32'd69;
    we_a1 = 1'b1; aw_a1 = 3'd4; dw_a1 = 16'd69;
    tick();
    idle();
    ar0 = {5'd4, 5'd4};
    ar1 = {4{3'd4}};
    for (int pass = 0; pass < 2; pass++) begin
      #1;
      for (int l = 0; l < 2; l++) begin
        checks++;
        if (dr0[l*32 +: 32] !== 32'd69) begin
          errors++;
          $display("FAIL basic0 pass%0d lane%0d got %h exp %h", pass, l, dr0[l*32 +: 32], 32'd69);
        end
      end
      for (int l = 0; l < 4; l++) begin
        checks++;
        if (dr1[l*16 +: 16] !== 16'd69) begin
          errors++;
          $display("FAIL basic1 pass%0d lane%0d got %h exp %h", pass, l, dr1[l*16 +: 16], 16'd69);
        end
      end
      // Second pass: disabled write with live address/data must not land.
      aw_a0 = 5'd4; dw_a0 = 32'd42; aw_a1 = 3'd4; dw_a1 = 16'd42;
      tick();
    end
    idle();
  endtask

  task automatic test_zero();
    idle();
    we_a0 = 1'b1; aw_a0 = 5'd0; dw_a0 = 32'd69;
    tick();
    idle();
    we_b0 = 1'b1; aw_b0 = 5'd0; dw_b0 = 32'd55;
    tick();
    idle();
    ar0 = '0;
    #1;
    for (int l = 0; l < 2; l++) begin
      checks++;
      if (dr0[l*32 +: 32] !== 32'd0) begin
        errors++;
        $display("FAIL zero_stored lane%0d got %h exp 0", l, dr0[l*32 +: 32]);
      end
    end
    we_a0 = 1'b1; aw_a0 = 5'd0; dw_a0 = 32'h77;
    we_b0 = 1'b1; aw_b0 = 5'd0; dw_b0 = 32'h88;
    #1;
    for (int l = 0; l < 2; l++) begin
      checks++;
      if (dr0[l*32 +: 32] !== 32'd0) begin
        errors++;
        $display("FAIL zero_bypass lane%0d got %h exp 0", l, dr0[l*32 +: 32]);
      end
    end
    tick();
    idle();
  endtask

  task automatic test_collision();
    idle();
    we_a0 = 1'b1; we_b0 = 1'b1; aw_a0 = 5'd15; aw_b0 = 5'd15; dw_a0 = 32'd420; dw_b0 = 32'd99;
    we_a1 = 1'b1; we_b1 = 1'b1; aw_a1 = 3'd6;  aw_b1 = 3'd6;  dw_a1 = 16'd420; dw_b1 = 16'd99;
    tick();
    idle();
    ar0 = {5'd15, 5'd15};
    ar1 = {4{3'd6}};
    #1;
    for (int l = 0; l < 2; l++) begin
      checks++;
      if (dr0[l*32 +: 32] !== 32'd99) begin
        errors++;
        $display("FAIL collide0 lane%0d got %h exp %h", l, dr0[l*32 +: 32], 32'd99);
      end
    end
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (dr1[l*16 +: 16] !== 16'd99) begin
        errors++;
        $display("FAIL collide1 lane%0d got %h exp %h", l, dr1[l*16 +: 16], 16'd99);
      end
    end
    we_a0 = 1'b1; aw_a0 = 5'd3; dw_a0 = 32'd11; we_b0 = 1'b1; aw_b0 = 5'd5; dw_b0 = 32'd22;
    we_a1 = 1'b1; aw_a1 = 3'd3; dw_a1 = 16'd11; we_b1 = 1'b1; aw_b1 = 3'd5; dw_b1 = 16'd22;
    tick();
    idle();
    ar0 = {5'd5, 5'd3};
    ar1 = {3'd5, 3'd3, 3'd5, 3'd3};
    #1;
    for (int l = 0; l < 2; l++) begin
      checks++;
      if (dr0[l*32 +: 32] !== ((l == 0) ? 32'd11 : 32'd22)) begin
        errors++;
        $display("FAIL distinct0 lane%0d got %h exp %h", l, dr0[l*32 +: 32], (l == 0) ? 32'd11 : 32'd22);
      end
    end
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (dr1[l*16 +: 16] !== ((l % 2 == 0) ? 16'd11 : 16'd22)) begin
        errors++;
        $display("FAIL distinct1 lane%0d got %h exp %h", l, dr1[l*16 +: 16], (l % 2 == 0) ? 16'd11 : 16'd22);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want0 [5];
    idle();
    we_a0 = 1'b1; aw_a0 = 5'd9; dw_a0 = 32'd1;
    we_a1 = 1'b1; aw_a1 = 3'd1; dw_a1 = 16'd1;
    tick();
    idle();
    ar0 = {5'd9, 5'd0};
    // Steps: B only, A and B, A only, nothing, then after the edge of a B write.
    want0[0] = 32'd77; want0[1] = 32'd77; want0[2] = 32'd66; want0[3] = 32'd1; want0[4] = 32'd77;
    for (int s = 0; s < 5; s++) begin
      we_a0 = (s == 1 || s == 2); aw_a0 = 5'd9; dw_a0 = 32'd66;
      we_b0 = (s <= 1 || s == 4); aw_b0 = 5'd9; dw_b0 = 32'd77;
      if (s == 4) begin
        tick();
        idle();
      end
      #1;
      checks++;
      if (dr0[63:32] !== want0[s]) begin
        errors++;
        $display("FAIL bypass0 step%0d got %h exp %h", s, dr0[63:32], want0[s]);
      end
    end
    we_b1 = 1'b1; aw_b1 = 3'd1; dw_b1 = 16'd77;
    ar1 = {4{3'd1}};
    #1;
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (dr1[l*16 +: 16] !== 16'd1) begin
        errors++;
        $display("FAIL nobypass_pre lane%0d got %h exp %h", l, dr1[l*16 +: 16], 16'd1);
      end
    end
    tick();
    idle();
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (dr1[l*16 +: 16] !== 16'd77) begin
        errors++;
        $display("FAIL nobypass_post lane%0d got %h exp %h", l, dr1[l*16 +: 16], 16'd77);
      end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] v;
    idle();
    we_a1 = 1'b1; aw_a1 = 3'd7; dw_a1 = 16'hFFFF;
    tick();
    idle();
    ar1 = {4{3'd7}};
    #1;
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (dr1[l*16 +: 16] !== 16'hFFFF) begin
        errors++;
        $display("FAIL sweep_ffff lane%0d got %h exp ffff", l, dr1[l*16 +: 16]);
      end
    end
    for (int a = 0; a < 8; a++) begin
      idle();
      v = 16'h1111 * 16'(a + 1);
      if (a % 2 == 0) begin
        we_a1 = 1'b1; aw_a1 = a[2:0]; dw_a1 = v;
      end else begin
        we_b1 = 1'b1; aw_b1 = a[2:0]; dw_b1 = v;
      end
      tick();
    end
    idle();
    for (int a = 0; a < 8; a++) begin
      for (int l = 0; l < 4; l++) ar1[l*3 +: 3] = 3'(a + l);
      #1;
      for (int l = 0; l < 4; l++) begin
        v = 16'h1111 * 16'(((a + l) % 8) + 1);
        checks++;
        if (dr1[l*16 +: 16] !== v) begin
          errors++;
          $display("FAIL sweep_addr%0d lane%0d got %h exp %h", (a + l) % 8, l, dr1[l*16 +: 16], v);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      we_a0 = 1'($urandom); we_b0 = 1'($urandom);
      aw_a0 = 5'($urandom);
      aw_b0 = ($urandom_range(0, 3) == 0) ? aw_a0 : 5'($urandom);
      dw_a0 = $urandom; dw_b0 = $urandom;
      ar0 = 10'($urandom);
      if ($urandom_range(0, 2) == 0) ar0[4:0] = aw_b0;
      if ($urandom_range(0, 2) == 0) ar0[9:5] = aw_a0;
      we_a1 = 1'($urandom); we_b1 = 1'($urandom);
      aw_a1 = 3'($urandom);
      aw_b1 = ($urandom_range(0, 3) == 0) ? aw_a1 : 3'($urandom);
      dw_a1 = 16'($urandom); dw_b1 = 16'($urandom);
      ar1 = 12'($urandom);
      #1;
      for (int l = 0; l < 2; l++) begin
        checks++;
        if (dr0[l*32 +: 32] !== exp0(ar0[l*5 +: 5])) begin
          errors++;
          $display("FAIL rand0 cyc%0d lane%0d addr%0d got %h exp %h", n, l, ar0[l*5 +: 5],
                   dr0[l*32 +: 32], exp0(ar0[l*5 +: 5]));
        end
      end
      for (int l = 0; l < 4; l++) begin
        checks++;
        if (dr1[l*16 +: 16] !== exp1(ar1[l*3 +: 3])) begin
          errors++;
          $display("FAIL rand1 cyc%0d lane%0d addr%0d got %h exp %h", n, l, ar1[l*3 +: 3],
                   dr1[l*16 +: 16], exp1(ar1[l*3 +: 3]));
        end
      end
      tick();
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    ar0 = '0;
    ar1 = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_zero();
    test_collision();
    test_bypass();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
